// File: rtl/aoi211_pipe_bank.sv
// aoi211_pipe_bank
//   WIDTH-bit bank of 211-type complex gates followed by a DEPTH-stage
//   register pipeline with valid tracking, occupancy count, a global
//   stall enable and a full scan chain through every data flop.
//
// Ports
//   CK     clock, rising edge
//   RN     asynchronous active-low reset
//   EN     pipeline advance enable (0 = stall)
//   VLD_I  input operands valid
//   MODE   00 AOI211, 01 AO211, 10 OAI211, 11 OA211
//   A, B, C1, C2  WIDTH-bit operands
//   SE     scan enable (overrides EN)
//   SI     scan data in
//   ZN     last-stage result
//   VLD_O  last-stage valid
//   OCC    number of valid stages (0..DEPTH)
//   SO     scan data out, always the last-stage MSB

module aoi211_pipe_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             EN,
  input  logic             VLD_I,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C1,
  input  logic [WIDTH-1:0] C2,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] ZN,
  output logic             VLD_O,
  output logic [CW-1:0]    OCC,
  output logic             SO
);

  localparam int NBITS = DEPTH * WIDTH;

  // All stages packed into one vector, stage 0 in the low WIDTH bits.
  // Scan then becomes a plain left shift with SI entering at bit 0.
  logic [NBITS-1:0] data_q, data_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [WIDTH-1:0] func;

  always_comb begin
    func = '0;
    case (MODE)
      2'b00:   func = ~((C1 & C2) | A | B);
      2'b01:   func =   (C1 & C2) | A | B;
      2'b10:   func = ~((C1 | C2) & A & B);
      default: func =   (C1 | C2) & A & B;
    endcase
  end

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (SE) begin
      // Valid bits hold during scan; only the data chain moves.
      data_d[0] = SI;
      for (int i = 1; i < NBITS; i++) begin
        data_d[i] = data_q[i-1];
      end
    end else if (EN) begin
      data_d[0 +: WIDTH] = func;
      vld_d[0]           = VLD_I;
      for (int s = 1; s < DEPTH; s++) begin
        data_d[s*WIDTH +: WIDTH] = data_q[(s-1)*WIDTH +: WIDTH];
        vld_d[s]                 = vld_q[s-1];
      end
    end
  end

  // Occupancy is the population count of the next valid vector, so it is
  // exact on every edge and cannot wrap.
  always_comb begin
    occ_d = '0;
    for (int s = 0; s < DEPTH; s++) begin
      occ_d = occ_d + CW'(vld_d[s]);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      data_q <= '0;
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end

  assign ZN    = data_q[(DEPTH-1)*WIDTH +: WIDTH];
  assign VLD_O = vld_q[DEPTH-1];
  assign OCC   = occ_q;
  assign SO    = data_q[NBITS-1];

endmodule

// File: tb/tb_aoi211_pipe_bank.sv
module tb_aoi211_pipe_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             CK;
  logic             RN;
  logic             EN;
  logic             VLD_I;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] A, B, C1, C2;
  logic             SE;
  logic             SI;
  logic [WIDTH-1:0] ZN;
  logic             VLD_O;
  logic [CW-1:0]    OCC;
  logic             SO;

  int n_chk = 0;
  int n_err = 0;

  aoi211_pipe_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CK(CK), .RN(RN), .EN(EN), .VLD_I(VLD_I), .MODE(MODE),
    .A(A), .B(B), .C1(C1), .C2(C2), .SE(SE), .SI(SI),
    .ZN(ZN), .VLD_O(VLD_O), .OCC(OCC), .SO(SO)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] zn, input logic vo, input logic [CW-1:0] oc);
    check({tag, ".zn"},  64'(ZN),    64'(zn));
    check({tag, ".vld"}, 64'(VLD_O), 64'(vo));
    check({tag, ".occ"}, 64'(OCC),   64'(oc));
  endtask

  // one rising edge, then settle on the falling edge
  task automatic tick();
    @(negedge CK);
  endtask

  logic [15:0] scan_pat;

  initial begin
    // ---------- reset with inputs unknown ----------
    RN = 1'b1;
    #1 RN = 1'b0;
    #1;
    outs("rst_async", 8'h00, 1'b0, 0);
    check("rst_async.so", 64'(SO), 64'd0);

    EN = 0; SE = 0; SI = 0; VLD_I = 0; MODE = 2'b00;
    A = 0; B = 0; C1 = 0; C2 = 0;
    @(negedge CK);
    RN = 1'b1;
    tick();
    outs("rst_release", 8'h00, 1'b0, 0);

    // ---------- single AOI211 sample ----------
    EN = 1; MODE = 2'b00; A = 8'h01; B = 8'h02; C1 = 8'hF0; C2 = 8'h30; VLD_I = 1;
    tick();
    outs("aoi.e1", 8'h00, 1'b0, 1);
    VLD_I = 0;
    tick();
    outs("aoi.e2", 8'hCC, 1'b1, 1);
    tick();
    outs("aoi.e3", 8'hCC, 1'b0, 0);

    // ---------- remaining modes back to back ----------
    MODE = 2'b01; VLD_I = 1;
    tick();
    MODE = 2'b10;
    tick();
    outs("mode01", 8'h33, 1'b1, 2);
    MODE = 2'b11;
    tick();
    outs("mode10", 8'hFF, 1'b1, 2);
    VLD_I = 0;
    tick();
    outs("mode11", 8'h00, 1'b1, 1);
    tick();
    check("mode.drain.vld", 64'(VLD_O), 64'd0);
    check("mode.drain.occ", 64'(OCC), 64'd0);

    // ---------- stream with a 3-cycle stall ----------
    MODE = 2'b01; B = 0; C1 = 0; C2 = 0;
    A = 8'h10; VLD_I = 1;
    tick();
    A = 8'h20;
    tick();
    outs("strm.s1", 8'h10, 1'b1, 2);
    EN = 0; A = 8'h40;
    for (int k = 0; k < 3; k++) begin
      tick();
      outs($sformatf("stall%0d", k), 8'h10, 1'b1, 2);
    end
    EN = 1;
    tick();
    outs("strm.s2", 8'h20, 1'b1, 2);
    A = 8'h80;
    tick();
    outs("strm.s3", 8'h40, 1'b1, 2);
    VLD_I = 0; A = 8'h00;
    tick();
    outs("strm.s4", 8'h80, 1'b1, 1);
    tick();
    check("strm.end.vld", 64'(VLD_O), 64'd0);
    check("strm.end.occ", 64'(OCC), 64'd0);

    // ---------- scan: last stage valid, first stage bubble ----------
    A = 8'h55; VLD_I = 1;
    tick();
    VLD_I = 0;
    tick();
    outs("prescan", 8'h55, 1'b1, 1);

    SE = 1; EN = 1; VLD_I = 1; MODE = 2'b00;
    scan_pat = 16'h3CA5;   // bit 0 shifted first: 0xA5 LSB first, then 0x3C
    for (int k = 0; k < 16; k++) begin
      SI = scan_pat[k];
      tick();
      check($sformatf("scan_in%0d.vld", k), 64'(VLD_O), 64'd1);
      check($sformatf("scan_in%0d.occ", k), 64'(OCC), 64'd1);
    end
    check("scan.par", 64'(ZN), 64'hA5);

    SI = 0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("scan_out%0d.so", k), 64'(SO), 64'(scan_pat[k]));
      tick();
      check($sformatf("scan_out%0d.vld", k), 64'(VLD_O), 64'd1);
      check($sformatf("scan_out%0d.occ", k), 64'(OCC), 64'd1);
      if (k == 7) check("scan.par2", 64'(ZN), 64'h3C);
    end
    check("scan.empty", 64'(ZN), 64'h00);

    // ---------- reset mid-stream ----------
    SE = 0; EN = 1; VLD_I = 0; MODE = 2'b01; A = 8'h11;
    tick();
    VLD_I = 1;
    tick();
    tick();
    outs("pre_rst", 8'h11, 1'b1, 2);
    #2 RN = 1'b0;
    #1;
    outs("mid_rst", 8'h00, 1'b0, 0);
    check("mid_rst.so", 64'(SO), 64'd0);
    @(negedge CK);
    RN = 1'b1;
    A = 8'h77; VLD_I = 1;
    tick();
    outs("post_rst.e1", 8'h00, 1'b0, 1);
    VLD_I = 0;
    tick();
    outs("post_rst.e2", 8'h77, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aoi211_pipe_bank.md
Name: aoi211_pipe_bank

Overview:
- Parametrised, registered successor to the single-bit AOI211 cell: a WIDTH-bit bank of 211-type complex gates with a DEPTH-stage pipeline.
- Per-operation mode select covers AOI211, AO211, OAI211 and OA211.
- Provides valid tracking, a global stall enable and a full scan chain through every pipeline flop.
- Used as a datapath macro wherever wide registered 211 logic is needed, replacing per-bit cell instantiation plus separate flops.

Parameters:
- WIDTH, 8, bits per operand and result; legal range 1..64.
- DEPTH, 2, pipeline stages from input to ZN; legal range 1..8.
- CW, $clog2(DEPTH+1), width of OCC; derived, not overridable.

Ports:
- CK  in  1  clock; all flops rise-edge triggered.
- RN  in  1  asynchronous active-low reset.
- EN  in  1  pipeline advance enable; 0 = stall.
- VLD_I  in  1  input operands valid.
- MODE  in  2  function select, sampled with operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C1  in  WIDTH  operand C1.
- C2  in  WIDTH  operand C2.
- SE  in  1  scan enable.
- SI  in  1  scan data in.
- ZN  out  WIDTH  result, output of the last stage.
- VLD_O  out  1  ZN valid.
- OCC  out  CW  count of valid entries in the pipeline.
- SO  out  1  scan data out.

Behaviour:
- Per-bit function, i = bit index:
  - MODE=00 AOI211: ZN=~((C1&C2)|A|B).
  - MODE=01 AO211: ZN=(C1&C2)|A|B.
  - MODE=10 OAI211: ZN=~((C1|C2)&A&B).
  - MODE=11 OA211: ZN=(C1|C2)&A&B.
- The function is evaluated combinationally before stage 0. Stage 0 stores the result plus VLD_I. Stages 1..DEPTH-1 copy the previous stage. ZN/VLD_O are the last stage.
- Latency: exactly DEPTH rising edges with EN=1 from operand sample to ZN. Throughput is one result per cycle.
- EN=0 with SE=0: every data and valid flop holds. Inputs are ignored and OCC holds.
- Invalid (VLD_I=0) samples still propagate as data bubbles. Their data field is the evaluated function, not forced to 0. Only the valid bit marks them.
- OCC equals the number of stages whose valid bit is 1, range 0..DEPTH. It is registered, updated on the same edge as the stages, and never wraps.
- Scan, SE=1 (overrides EN):
  - On each edge the data flops shift as one chain of DEPTH*WIDTH bits.
  - Order: SI -> stage0 bit0 -> stage0 bit WIDTH-1 -> stage1 bit0 ... -> last stage bit WIDTH-1 -> SO.
  - Valid flops and OCC hold during scan.
  - The function inputs are ignored.
  - SO is the registered last-stage MSB at all times, not only when SE=1.
- Reset, RN=0, asynchronous, no clock needed:
  - All data flops 0, so ZN=0 regardless of MODE. Note this differs from AOI211 of all-zero inputs, which is 1.
  - VLD_O=0, OCC=0, SO=0.
- Reset mid-operation discards all in-flight entries immediately.
- Deassertion is taken synchronously by the integrating design. The block requires only that RN rise away from CK edges.
- Simultaneous SE=1 and EN=1: scan shift wins. No functional capture occurs.
- VLD_I=1 with EN=0: the sample is dropped. The upstream must hold its operands until EN=1.
- DEPTH=1: ZN is the directly registered function and OCC is 1 bit.

Test Plan:
- Reset with all inputs X, then RN=0 -> ZN=0x00, VLD_O=0, OCC=0, SO=0 without a clock edge. Release RN -> state holds.
- WIDTH=8, DEPTH=2, EN=1, MODE=00, A=0x01, B=0x02, C1=0xF0, C2=0x30, VLD_I=1 for one cycle -> after 2 edges ZN=0xCC, VLD_O=1 for exactly one cycle; OCC sequence 1,1,0.
- Same operands across MODE 01/10/11 on consecutive cycles -> ZN sequence 0x33, 0xFF, 0x00 at 2-cycle latency, back-to-back with VLD_O held at 1.
- Stream 4 valid samples, with EN=0 for 3 cycles mid-stream -> ZN/VLD_O/OCC frozen (OCC=2) during the stall, order preserved, no sample lost or duplicated.
- SE=1, shift pattern 0xA5 then 0x3C into SI (16 edges, LSB first) -> parallel contents readable on ZN. A further 16 edges shift the same bits out on SO in order. VLD_O and OCC unchanged throughout.
- Assert RN=0 mid-stream with OCC=2 -> immediately ZN=0, VLD_O=0, OCC=0. The first post-reset valid input appears after exactly DEPTH edges.
